// File: rtl/hazard_pkg.sv
// Shared encodings for the D-stage hazard scoreboard: Tuse/Tnew stage offsets and the
// multiply/divide start codes.
package hazard_pkg;

    // Cycles from D until an operand is consumed
    localparam int unsigned TUSE_D = 0;
    localparam int unsigned TUSE_E = 1;
    localparam int unsigned TUSE_M = 2;

    // Cycles after entering E until a result is forwardable
    localparam int unsigned TNEW_NONE   = 0;
    localparam int unsigned TNEW_ALU    = 1;
    localparam int unsigned TNEW_MFHILO = 1;
    localparam int unsigned TNEW_LINK   = 1;
    localparam int unsigned TNEW_LOAD   = 2;

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MULT = 2'b01,
        MD_DIV  = 2'b10,
        MD_RSVD = 2'b11
    } md_start_e;

endpackage

// File: rtl/md_busy_timer.sv
// HI/LO busy countdown: loaded with the mult or div latency when a start issues,
// otherwise counts down to zero.
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned MD_CW    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue,
    input  logic [1:0] md_start,
    output logic       md_busy
);

    logic [MD_CW-1:0] md_cnt;
    logic [MD_CW-1:0] md_cnt_next;

    // A start only issues with md_cnt==0, so a load never races a running count
    always_comb begin
        md_cnt_next = md_cnt;
        if (issue && md_start == MD_MULT) begin
            md_cnt_next = MD_CW'(MULT_LAT);
        end else if (issue && md_start == MD_DIV) begin
            md_cnt_next = MD_CW'(DIV_LAT);
        end else if (md_cnt != '0) begin
            md_cnt_next = md_cnt - MD_CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= '0;
        end else begin
            md_cnt <= md_cnt_next;
        end
    end

    assign md_busy = (md_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage stall controller: per-GPR Tnew countdown scoreboard plus HI/LO busy timer,
// driving PC/D enables, the E-register bubble and a saturating stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_NUM  = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned TNEW_W   = 2,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned MD_CW    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] rs_D,
    input  logic [REG_AW-1:0] rt_D,
    input  logic              use_rs,
    input  logic              use_rt,
    input  logic [TNEW_W-1:0] tuse_rs,
    input  logic [TNEW_W-1:0] tuse_rt,
    input  logic              wr_D,
    input  logic [REG_AW-1:0] dst_D,
    input  logic [TNEW_W-1:0] tnew_D,
    input  logic              md_op_D,
    input  logic [1:0]        md_start_D,
    output logic              pc_en,
    output logic              d_en,
    output logic              e_reset,
    output logic              md_busy,
    output logic [31:0]       stall_cycles
);

    logic [TNEW_W-1:0] cnt      [REG_NUM];
    logic [TNEW_W-1:0] cnt_next [REG_NUM];
    logic              hz_rs;
    logic              hz_rt;
    logic              hz_md;
    logic              stall;
    logic              issue;

    assign hz_rs = d_valid & use_rs & (rs_D != '0) & (cnt[rs_D] > tuse_rs);
    assign hz_rt = d_valid & use_rt & (rt_D != '0) & (cnt[rt_D] > tuse_rt);
    assign hz_md = d_valid & md_op_D & md_busy;

    assign stall   = hz_rs | hz_rt | hz_md;
    assign issue   = d_valid & ~stall;
    assign pc_en   = ~stall;
    assign d_en    = ~stall;
    assign e_reset = stall;

    // E/M/W never stall, so counters keep draining while D is held
    always_comb begin
        for (int r = 0; r < REG_NUM; r++) begin
            cnt_next[r] = '0;
            if (r != 0) begin
                if (issue && wr_D && dst_D == REG_AW'(r)) begin
                    cnt_next[r] = tnew_D;
                end else if (cnt[r] != '0) begin
                    cnt_next[r] = cnt[r] - TNEW_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < REG_NUM; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < REG_NUM; r++) begin
                cnt[r] <= cnt_next[r];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

    md_busy_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .MD_CW    (MD_CW)
    ) u_md_busy_timer (
        .clk      (clk),
        .reset    (reset),
        .issue    (issue),
        .md_start (md_start_D),
        .md_busy  (md_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic, all checked
// each cycle against a ready-time model of register results and the HI/LO unit.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic        clk;
    logic        reset;
    logic        d_valid;
    logic [4:0]  rs_D;
    logic [4:0]  rt_D;
    logic        use_rs;
    logic        use_rt;
    logic [1:0]  tuse_rs;
    logic [1:0]  tuse_rt;
    logic        wr_D;
    logic [4:0]  dst_D;
    logic [1:0]  tnew_D;
    logic        md_op_D;
    logic [1:0]  md_start_D;
    logic        pc_en;
    logic        d_en;
    logic        e_reset;
    logic        md_busy;
    logic [31:0] stall_cycles;

    hazard_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .d_valid      (d_valid),
        .rs_D         (rs_D),
        .rt_D         (rt_D),
        .use_rs       (use_rs),
        .use_rt       (use_rt),
        .tuse_rs      (tuse_rs),
        .tuse_rt      (tuse_rt),
        .wr_D         (wr_D),
        .dst_D        (dst_D),
        .tnew_D       (tnew_D),
        .md_op_D      (md_op_D),
        .md_start_D   (md_start_D),
        .pc_en        (pc_en),
        .d_en         (d_en),
        .e_reset      (e_reset),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       use_rs;
        logic [4:0] rs;
        logic [1:0] tuse_rs;
        logic       use_rt;
        logic [4:0] rt;
        logic [1:0] tuse_rt;
        logic       wr;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic       md_op;
        logic [1:0] md_start;
    } instr_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: absolute cycle at which each result / the HI/LO unit becomes available
    longint now;
    longint ready [32];
    longint md_free;
    longint exp_sc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input int urs, input int rs, input int trs, input int urt,
                                  input int rt, input int trt, input int wr, input int dst,
                                  input int tnew, input int mdop, input int mds);
        instr_t i;
        i.use_rs   = 1'(urs);
        i.rs       = 5'(rs);
        i.tuse_rs  = 2'(trs);
        i.use_rt   = 1'(urt);
        i.rt       = 5'(rt);
        i.tuse_rt  = 2'(trt);
        i.wr       = 1'(wr);
        i.dst      = 5'(dst);
        i.tnew     = 2'(tnew);
        i.md_op    = 1'(mdop);
        i.md_start = 2'(mds);
        return i;
    endfunction

    function automatic longint remaining(input int r);
        if (r == 0 || ready[r] <= now) return 0;
        return ready[r] - now;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) ready[r] = 0;
        md_free = 0;
        exp_sc  = 0;
    endtask

    task automatic drive(input instr_t ins, input logic valid);
        d_valid    = valid;
        use_rs     = ins.use_rs;
        rs_D       = ins.rs;
        tuse_rs    = ins.tuse_rs;
        use_rt     = ins.use_rt;
        rt_D       = ins.rt;
        tuse_rt    = ins.tuse_rt;
        wr_D       = ins.wr;
        dst_D      = ins.dst;
        tnew_D     = ins.tnew;
        md_op_D    = ins.md_op;
        md_start_D = ins.md_start;
    endtask

    // Compare DUT outputs with the model for the current inputs, then advance the model
    task automatic check_cycle(output logic stalled, output logic busy);
        logic hz_rs, hz_rt, hz_md, exp_stall;
        busy      = (md_free > now);
        hz_rs     = d_valid && use_rs && rs_D != 0 && remaining(int'(rs_D)) > longint'(tuse_rs);
        hz_rt     = d_valid && use_rt && rt_D != 0 && remaining(int'(rt_D)) > longint'(tuse_rt);
        hz_md     = d_valid && md_op_D && busy;
        exp_stall = hz_rs || hz_rt || hz_md;
        chk("pc_en", 64'(pc_en), 64'(!exp_stall));
        chk("d_en", 64'(d_en), 64'(!exp_stall));
        chk("e_reset", 64'(e_reset), 64'(exp_stall));
        chk("md_busy", 64'(md_busy), 64'(busy));
        chk("stall_cycles", 64'(stall_cycles), 64'(exp_sc));
        stalled = exp_stall;
        if (exp_stall && exp_sc < 64'hFFFF_FFFF) exp_sc++;
        if (d_valid && !exp_stall) begin
            if (wr_D && dst_D != 0) ready[dst_D] = now + 1 + longint'(tnew_D);
            if (md_start_D == MD_MULT) md_free = now + 1 + 5;
            if (md_start_D == MD_DIV) md_free = now + 1 + 10;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        now++;
        #1;
    endtask

    // Hold one instruction in D until it issues; report stall and busy cycle counts
    task automatic run(input instr_t ins, output int stalls, output int busys);
        logic st, bz;
        int   guard;
        stalls = 0;
        busys  = 0;
        guard  = 0;
        drive(ins, 1'b1);
        do begin
            @(negedge clk);
            check_cycle(st, bz);
            if (st) stalls++;
            if (bz) busys++;
            tick();
            guard++;
        end while (st && guard < 30);
        if (st) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: instruction still stalled after %0d cycles", guard);
        end
    endtask

    task automatic bubbles(input int n);
        logic st, bz;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_cycle(st, bz);
            tick();
        end
    endtask

    instr_t nop_i, mult_i, div_i, mflo_i;
    int s, b;
    logic st, bz;

    initial begin
        now = 0;
        model_reset();
        reset = 1'b0;
        nop_i  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MD_NONE);
        mult_i = mk(1, 8, 0, 1, 9, 0, 0, 0, 0, 1, MD_MULT);
        div_i  = mk(1, 8, 0, 1, 9, 0, 0, 0, 0, 1, MD_DIV);
        mflo_i = mk(0, 0, 0, 0, 0, 0, 1, 10, TNEW_MFHILO, 1, MD_NONE);

        // Inputs that would hazard if any state were pending
        drive(mk(1, 1, 0, 1, 2, 0, 1, 1, 3, 1, MD_DIV), 1'b1);
        #1 reset = 1'b1;
        #2;
        chk("rst_pc_en", 64'(pc_en), 64'(1));
        chk("rst_d_en", 64'(d_en), 64'(1));
        chk("rst_e_reset", 64'(e_reset), 64'(0));
        chk("rst_md_busy", 64'(md_busy), 64'(0));
        chk("rst_stall_cycles", 64'(stall_cycles), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Load-use
        run(mk(0, 0, 0, 0, 0, 0, 1, 1, TNEW_LOAD, 0, 0), s, b);
        run(mk(1, 1, TUSE_E, 1, 0, 0, 1, 7, TNEW_ALU, 0, 0), s, b);
        chk("load_use_stalls", 64'(s), 64'(1));
        chk("load_use_stall_cycles", 64'(stall_cycles), 64'(1));

        // Branch after ALU
        run(mk(0, 0, 0, 0, 0, 0, 1, 2, TNEW_ALU, 0, 0), s, b);
        run(mk(1, 2, TUSE_D, 0, 0, 0, 0, 0, 0, 0, 0), s, b);
        chk("branch_tuse0_stalls", 64'(s), 64'(1));
        run(mk(0, 0, 0, 0, 0, 0, 1, 2, TNEW_ALU, 0, 0), s, b);
        run(mk(1, 2, TUSE_E, 0, 0, 0, 0, 0, 0, 0, 0), s, b);
        chk("branch_tuse1_stalls", 64'(s), 64'(0));

        // $0 immunity
        run(mk(0, 0, 0, 0, 0, 0, 1, 0, TNEW_LOAD, 0, 0), s, b);
        run(mk(1, 0, TUSE_D, 1, 0, TUSE_D, 1, 4, TNEW_ALU, 0, 0), s, b);
        chk("zero_reg_stalls", 64'(s), 64'(0));

        // HI/LO timing
        run(mult_i, s, b);
        run(mflo_i, s, b);
        chk("mult_mflo_stalls", 64'(s), 64'(5));
        chk("mult_busy_cycles", 64'(b), 64'(5));
        run(div_i, s, b);
        run(mflo_i, s, b);
        chk("div_mflo_stalls", 64'(s), 64'(10));
        chk("div_busy_cycles", 64'(b), 64'(10));
        run(div_i, s, b);
        run(mk(1, 5, TUSE_E, 1, 6, TUSE_E, 1, 11, TNEW_ALU, 0, 0), s, b);
        chk("div_non_md_stalls", 64'(s), 64'(0));
        bubbles(12);

        // Newest producer wins over decrement
        run(mk(0, 0, 0, 0, 0, 0, 1, 3, TNEW_LOAD, 0, 0), s, b);
        run(mk(1, 3, TUSE_M, 0, 0, 0, 1, 3, TNEW_ALU, 0, 0), s, b);
        run(mk(1, 3, TUSE_D, 0, 0, 0, 0, 0, 0, 0, 0), s, b);
        chk("overwrite_stalls", 64'(s), 64'(1));
        run(mk(0, 0, 0, 0, 0, 0, 1, 4, 1, 0, 0), s, b);
        run(mk(0, 0, 0, 0, 0, 0, 1, 4, TNEW_LOAD, 0, 0), s, b);
        run(mk(1, 4, TUSE_D, 0, 0, 0, 0, 0, 0, 0, 0), s, b);
        chk("reload_stalls", 64'(s), 64'(2));

        // Simultaneous rs/rt hazards release together
        run(mk(0, 0, 0, 0, 0, 0, 1, 5, TNEW_LOAD, 0, 0), s, b);
        run(mk(0, 0, 0, 0, 0, 0, 1, 6, TNEW_LOAD, 0, 0), s, b);
        run(mk(1, 5, TUSE_D, 1, 6, TUSE_D, 0, 0, 0, 0, 0), s, b);
        chk("dual_hazard_stalls", 64'(s), 64'(2));
        bubbles(4);

        // Async reset in the middle of a div stall
        run(div_i, s, b);
        drive(mflo_i, 1'b1);
        @(negedge clk);
        check_cycle(st, bz);
        tick();
        chk("pre_reset_pc_en", 64'(pc_en), 64'(0));
        chk("pre_reset_md_busy", 64'(md_busy), 64'(1));
        #1 reset = 1'b1;
        model_reset();
        #1;
        chk("mid_reset_md_busy", 64'(md_busy), 64'(0));
        chk("mid_reset_pc_en", 64'(pc_en), 64'(1));
        chk("mid_reset_stall_cycles", 64'(stall_cycles), 64'(0));
        #1 reset = 1'b0;
        @(negedge clk);
        check_cycle(st, bz);
        chk("post_reset_mflo_stall", 64'(st), 64'(0));
        tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            d_valid    = ($urandom_range(0, 9) < 8);
            use_rs     = 1'($urandom_range(0, 1));
            use_rt     = 1'($urandom_range(0, 1));
            rs_D       = 5'($urandom_range(0, 7));
            rt_D       = 5'($urandom_range(0, 7));
            tuse_rs    = 2'($urandom_range(0, 3));
            tuse_rt    = 2'($urandom_range(0, 3));
            wr_D       = 1'($urandom_range(0, 1));
            dst_D      = 5'($urandom_range(0, 7));
            tnew_D     = 2'($urandom_range(0, 3));
            md_op_D    = ($urandom_range(0, 4) == 0);
            md_start_D = md_op_D ? 2'($urandom_range(0, 3)) : 2'b00;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                model_reset();
                #1 reset = 1'b0;
            end
            @(negedge clk);
            check_cycle(st, bz);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
